// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer widths, pixel codes and {x,y} address packing
package fb_pkg;

  localparam int FB_X_W    = 10;
  localparam int FB_Y_W    = 9;
  localparam int FB_ADDR_W = FB_X_W + FB_Y_W;

  localparam logic [1:0] PIX_WHITE   = 2'b00;
  localparam logic [1:0] PIX_T1      = 2'b01;
  localparam logic [1:0] PIX_T2      = 2'b10;
  localparam logic [1:0] PIX_SPECIAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ERASE
  } wr_state_e;

  typedef enum logic {
    GNT_T1,
    GNT_T2
  } grant_e;

  function automatic logic [FB_ADDR_W-1:0] fb_pack(input logic [FB_X_W-1:0] x,
                                                   input logic [FB_Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/fb_sweep_counter.sv
// rtl/fb_sweep_counter.sv - x/y raster counter, y fastest, shared by clear and column erase
module fb_sweep_counter
  import fb_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [FB_X_W-1:0] load_x_i,
  input  logic              step_i,
  input  logic              step_x_i,
  output logic [FB_X_W-1:0] x_o,
  output logic [FB_Y_W-1:0] y_o,
  output logic              y_last_o,
  output logic              last_o
);

  localparam logic [FB_X_W-1:0] X_LAST = FB_X_W'(SCREEN_W - 1);
  localparam logic [FB_Y_W-1:0] Y_LAST = FB_Y_W'(SCREEN_H - 1);

  logic [FB_X_W-1:0] x_q, x_d;
  logic [FB_Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = load_x_i;
      y_d = '0;
    end else if (step_i) begin
      // Wrap on the visible row count, not the counter width.
      if (y_q == Y_LAST) begin
        y_d = '0;
        if (step_x_i) x_d = x_q + 10'd1;
      end else begin
        y_d = y_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign y_last_o = (y_q == Y_LAST);
  assign last_o   = (y_q == Y_LAST) && (x_q == X_LAST);

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - sole owner of frame-buffer port A: clear, column erase, two traces
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [1:0] CLEAR_COLOR = PIX_WHITE,
  parameter logic [1:0] T1_COLOR    = PIX_T1,
  parameter logic [1:0] T2_COLOR    = PIX_T2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  input  logic                 ce_valid,
  input  logic [FB_X_W-1:0]    ce_x,
  output logic                 ce_ready,
  input  logic                 t1_valid,
  input  logic [FB_X_W-1:0]    t1_x,
  input  logic [FB_Y_W-1:0]    t1_y,
  output logic                 t1_ready,
  input  logic                 t2_valid,
  input  logic [FB_X_W-1:0]    t2_x,
  input  logic [FB_Y_W-1:0]    t2_y,
  output logic                 t2_ready,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [1:0]           fb_data,
  output logic                 fb_wren
);

  localparam logic [FB_X_W-1:0] X_LAST = FB_X_W'(SCREEN_W - 1);
  localparam logic [FB_Y_W-1:0] Y_LAST = FB_Y_W'(SCREEN_H - 1);

  wr_state_e             state_q;
  grant_e                last_grant_q;
  logic [FB_ADDR_W-1:0]  fb_addr_q;
  logic [1:0]            fb_data_q;
  logic                  fb_wren_q;
  logic                  clear_busy_q;
  logic                  clear_done_q;

  logic                  cnt_load, cnt_step, cnt_step_x;
  logic [FB_X_W-1:0]     cnt_load_x;
  logic [FB_X_W-1:0]     cnt_x;
  logic [FB_Y_W-1:0]     cnt_y;
  logic                  cnt_y_last, cnt_last;

  logic                  idle, trace_slot, ce_in_range, t1_in_range, t2_in_range;

  assign idle        = (state_q == ST_IDLE);
  assign trace_slot  = idle && !clear_req && !ce_valid;
  assign ce_in_range = (ce_x <= X_LAST);
  assign t1_in_range = (t1_x <= X_LAST) && (t1_y <= Y_LAST);
  assign t2_in_range = (t2_x <= X_LAST) && (t2_y <= Y_LAST);

  assign ce_ready = idle && !clear_req && ce_valid;
  assign t1_ready = trace_slot && t1_valid && (!t2_valid || last_grant_q == GNT_T2);
  assign t2_ready = trace_slot && t2_valid && (!t1_valid || last_grant_q == GNT_T1);

  always_comb begin
    cnt_load   = 1'b0;
    cnt_load_x = '0;
    cnt_step   = 1'b0;
    cnt_step_x = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          cnt_load = 1'b1;
        end else if (ce_valid && ce_in_range) begin
          cnt_load   = 1'b1;
          cnt_load_x = ce_x;
        end
      end
      ST_CLEAR: begin
        cnt_step   = 1'b1;
        cnt_step_x = 1'b1;
      end
      ST_ERASE: begin
        if (clear_req) cnt_load = 1'b1;
        else           cnt_step = 1'b1;
      end
      default: ;
    endcase
  end

  fb_sweep_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .clk      (clk),
    .reset    (reset),
    .load_i   (cnt_load),
    .load_x_i (cnt_load_x),
    .step_i   (cnt_step),
    .step_x_i (cnt_step_x),
    .x_o      (cnt_x),
    .y_o      (cnt_y),
    .y_last_o (cnt_y_last),
    .last_o   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_T2;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_wren_q    <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      fb_wren_q    <= 1'b0;
      clear_done_q <= 1'b0;
      // Busy covers the cycle after the request through the final write.
      clear_busy_q <= (state_q == ST_CLEAR) || clear_req;
      unique case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
          end else if (ce_valid) begin
            if (ce_in_range) state_q <= ST_ERASE;
          end else if (t1_ready) begin
            if (t2_valid) last_grant_q <= GNT_T1;
            if (t1_in_range) begin
              fb_wren_q <= 1'b1;
              fb_addr_q <= fb_pack(t1_x, t1_y);
              fb_data_q <= T1_COLOR;
            end
          end else if (t2_ready) begin
            if (t1_valid) last_grant_q <= GNT_T2;
            if (t2_in_range) begin
              fb_wren_q <= 1'b1;
              fb_addr_q <= fb_pack(t2_x, t2_y);
              fb_data_q <= T2_COLOR;
            end
          end
        end
        ST_CLEAR: begin
          fb_wren_q <= 1'b1;
          fb_addr_q <= fb_pack(cnt_x, cnt_y);
          fb_data_q <= CLEAR_COLOR;
          if (cnt_last) begin
            clear_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_ERASE: begin
          // A clear supersedes the erase; the sweep repaints that column anyway.
          if (clear_req) begin
            state_q <= ST_CLEAR;
          end else begin
            fb_wren_q <= 1'b1;
            fb_addr_q <= fb_pack(cnt_x, cnt_y);
            fb_data_q <= CLEAR_COLOR;
            if (cnt_y_last) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_wren    = fb_wren_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - scoreboard bench for the frame-buffer write scheduler
module tb_fb_write_scheduler;
  import fb_pkg::*;

  // Reduced screen keeps full clear sweeps short; coordinates below are chosen to fit.
  localparam int W = 120;
  localparam int H = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, clear_req, ce_valid, t1_valid, t2_valid;
  logic [FB_X_W-1:0]    ce_x, t1_x, t2_x;
  logic [FB_Y_W-1:0]    t1_y, t2_y;
  logic                 clear_busy, clear_done, ce_ready, t1_ready, t2_ready;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [1:0]           fb_data;
  logic                 fb_wren;

  fb_write_scheduler #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done), .ce_valid(ce_valid), .ce_x(ce_x), .ce_ready(ce_ready),
    .t1_valid(t1_valid), .t1_x(t1_x), .t1_y(t1_y), .t1_ready(t1_ready),
    .t2_valid(t2_valid), .t2_x(t2_x), .t2_y(t2_y), .t2_ready(t2_ready),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren)
  );

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [1:0]           data;
    logic                 done;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   sb_e;
  int     errors = 0;
  int     checks = 0;
  bit     sb_en  = 1'b1;
  int     wr_count = 0;
  grant_e lg = GNT_T2;

  // Each write is checked in order against what the stimulus predicted.
  always @(negedge clk) begin
    if (fb_wren) wr_count++;
    if (sb_en && !reset) begin
      if (fb_wren) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr=%h data=%b, expected no write", fb_addr, fb_data);
        end else begin
          sb_e = sb_q.pop_front();
          if ({fb_addr, fb_data, clear_done} !== {sb_e.addr, sb_e.data, sb_e.done}) begin
            errors++;
            $display("FAIL sb_write: got addr=%h data=%b done=%b, expected addr=%h data=%b done=%b",
                     fb_addr, fb_data, clear_done, sb_e.addr, sb_e.data, sb_e.done);
          end
        end
      end else if (clear_done) begin
        checks++;
        errors++;
        $display("FAIL sb_done_without_write: clear_done=1 with fb_wren=0");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_req = 1'b0; ce_valid = 1'b0; ce_x = '0;
    t1_valid = 1'b0; t1_x = '0; t1_y = '0; t2_valid = 1'b0; t2_x = '0; t2_y = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({fb_addr, fb_data, fb_wren, clear_busy, clear_done, ce_ready, t1_ready, t2_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%b wren=%b busy=%b done=%b rdy=%b%b%b, expected all 0",
               fb_addr, fb_data, fb_wren, clear_busy, clear_done, ce_ready, t1_ready, t2_ready);
    end
  endtask

  task automatic test_single();
    tick();
    t1_valid = 1'b1; t1_x = 10'd100; t1_y = 9'd200;
    @(negedge clk);
    checks++;
    if (t1_ready !== 1'b1 || t2_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got t1=%b t2=%b, expected t1=1 t2=0", t1_ready, t2_ready);
    end
    sb_q.push_back('{fb_pack(10'd100, 9'd200), PIX_T1, 1'b0});
    tick();
    t1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fb_wren !== 1'b1 || fb_addr !== {10'd100, 9'd200} || fb_data !== 2'b01) begin
      errors++;
      $display("FAIL single_write: got wren=%b addr=%h data=%b, expected wren=1 addr=%h data=01",
               fb_wren, fb_addr, fb_data, {10'd100, 9'd200});
    end
  endtask

  task automatic test_back_to_back();
    bit exp1;
    tick();
    t1_valid = 1'b1; t1_x = 10'd10; t1_y = 9'd20;
    t2_valid = 1'b1; t2_x = 10'd30; t2_y = 9'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp1 = (lg == GNT_T2);
      checks++;
      if (t1_ready !== exp1 || t2_ready !== !exp1) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got t1=%b t2=%b, expected t1=%b t2=%b", i, t1_ready, t2_ready, exp1, !exp1);
      end
      if (exp1) begin
        sb_q.push_back('{fb_pack(10'd10, 9'd20), PIX_T1, 1'b0});
        lg = GNT_T1;
      end else begin
        sb_q.push_back('{fb_pack(10'd30, 9'd40), PIX_T2, 1'b0});
        lg = GNT_T2;
      end
      tick();
    end
    t1_valid = 1'b0; t2_valid = 1'b0;
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_clear();
    int  stall_err = 0;
    bit  seen = 1'b0;
    tick();
    clear_req = 1'b1;
    t1_valid = 1'b1; t1_x = 10'd5; t1_y = 9'd6;
    @(negedge clk);
    checks++;
    if (t1_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_blocks_trace: got t1_ready=%b, expected 0", t1_ready);
    end
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        sb_q.push_back('{fb_pack(FB_X_W'(x), FB_Y_W'(y)), PIX_WHITE, (x == W-1 && y == H-1)});
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    checks++;
    if (clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_start: got %b, expected 1", clear_busy);
    end
    for (int n = 0; n < W*H + 20; n++) begin
      if (clear_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (t1_ready !== 1'b0 || clear_busy !== 1'b1) stall_err++;
      tick();
      clear_req = (n == 100);
      @(negedge clk);
    end
    clear_req = 1'b0;
    checks++;
    if (!seen || stall_err != 0) begin
      errors++;
      $display("FAIL clear_sweep: got done_seen=%b stall_or_busy_errors=%0d, expected done_seen=1 errors=0", seen, stall_err);
    end
    checks++;
    if (clear_busy !== 1'b1 || t1_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_end_cycle: got busy=%b t1_ready=%b, expected busy=1 t1_ready=1", clear_busy, t1_ready);
    end
    sb_q.push_back('{fb_pack(10'd5, 9'd6), PIX_T1, 1'b0});
    tick();
    t1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy_end: got %b, expected 0", clear_busy);
    end
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL clear_drain: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_erase();
    int stall_err = 0;
    tick();
    ce_valid = 1'b1; ce_x = 10'd37;
    t2_valid = 1'b1; t2_x = 10'd50; t2_y = 9'd60;
    @(negedge clk);
    checks++;
    if (ce_ready !== 1'b1 || t2_ready !== 1'b0) begin
      errors++;
      $display("FAIL erase_accept: got ce_ready=%b t2_ready=%b, expected 1 and 0", ce_ready, t2_ready);
    end
    for (int y = 0; y < H; y++)
      sb_q.push_back('{fb_pack(10'd37, FB_Y_W'(y)), PIX_WHITE, 1'b0});
    for (int k = 1; k <= H; k++) begin
      tick();
      ce_valid = 1'b0;
      @(negedge clk);
      if (t2_ready !== 1'b0 || ce_ready !== 1'b0) stall_err++;
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL erase_stall: got %0d cycles with a ready high, expected 0", stall_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (t2_ready !== 1'b1) begin
      errors++;
      $display("FAIL erase_then_t2: got t2_ready=%b, expected 1", t2_ready);
    end
    sb_q.push_back('{fb_pack(10'd50, 9'd60), PIX_T2, 1'b0});
    tick();
    t2_valid = 1'b0;
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL erase_drain: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_out_of_range();
    int base;
    bit exp1;
    base = wr_count;
    tick();
    t1_valid = 1'b1; t1_x = FB_X_W'(W); t1_y = 9'd5;
    t2_valid = 1'b1; t2_x = 10'd3;       t2_y = FB_Y_W'(H);
    @(negedge clk);
    exp1 = (lg == GNT_T2);
    checks++;
    if (t1_ready !== exp1 || t2_ready !== !exp1) begin
      errors++;
      $display("FAIL oor_tie: got t1=%b t2=%b, expected t1=%b t2=%b", t1_ready, t2_ready, exp1, !exp1);
    end
    lg = exp1 ? GNT_T1 : GNT_T2;
    tick();
    if (exp1) t1_valid = 1'b0; else t2_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ((exp1 ? t2_ready : t1_ready) !== 1'b1) begin
      errors++;
      $display("FAIL oor_second: got ready=0, expected 1");
    end
    tick();
    t1_valid = 1'b1; t1_x = 10'd1023; t1_y = 9'd0; t2_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (t1_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_x_max: got t1_ready=%b, expected 1", t1_ready);
    end
    tick();
    t1_valid = 1'b0;
    ce_valid = 1'b1; ce_x = 10'd700;
    @(negedge clk);
    checks++;
    if (ce_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_erase_accept: got ce_ready=%b, expected 1", ce_ready);
    end
    tick();
    ce_valid = 1'b0;
    t1_valid = 1'b1; t1_x = 10'd7; t1_y = 9'd8;
    @(negedge clk);
    checks++;
    if (t1_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_erase_stays_idle: got t1_ready=%b, expected 1", t1_ready);
    end
    sb_q.push_back('{fb_pack(10'd7, 9'd8), PIX_T1, 1'b0});
    tick();
    t1_valid = 1'b0;
    tick(); tick();
    checks++;
    if (wr_count - base != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL oor_write_count: got %0d writes (%0d outstanding), expected 1 (0)", wr_count - base, sb_q.size());
    end
  endtask

  task automatic test_abandon_reset();
    int base;
    bit found = 1'b0;
    sb_en = 1'b0;
    sb_q.delete();
    tick();
    ce_valid = 1'b1; ce_x = 10'd37;
    @(negedge clk);
    base = wr_count;
    tick();
    ce_valid = 1'b0;
    for (int n = 0; n < 2*H; n++) begin
      @(negedge clk);
      if (wr_count - base >= 100) break;
      tick();
    end
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (fb_wren === 1'b1 && fb_addr === '0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found || fb_data !== PIX_WHITE || clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL abandon_clear_start: got found=%b data=%b busy=%b, expected found=1 data=00 busy=1",
               found, fb_data, clear_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fb_wren !== 1'b1 || fb_addr !== fb_pack(10'd0, 9'd1)) begin
      errors++;
      $display("FAIL abandon_clear_second: got wren=%b addr=%h, expected wren=1 addr=%h", fb_wren, fb_addr, fb_pack(10'd0, 9'd1));
    end
    base = wr_count;
    for (int n = 0; n < 1200; n++) begin
      if (wr_count - base >= 1000) break;
      tick();
      @(negedge clk);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lg = GNT_T2;
    @(negedge clk);
    checks++;
    if ({fb_addr, fb_data, fb_wren, clear_busy, clear_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got addr=%h data=%b wren=%b busy=%b done=%b, expected all 0",
               fb_addr, fb_data, fb_wren, clear_busy, clear_done);
    end
    tick();
    t1_valid = 1'b1; t1_x = 10'd11; t1_y = 9'd12;
    t2_valid = 1'b1; t2_x = 10'd13; t2_y = 9'd14;
    @(negedge clk);
    checks++;
    if (fb_wren !== 1'b0 || t1_ready !== 1'b1 || t2_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_grant: got wren=%b t1=%b t2=%b, expected wren=0 t1=1 t2=0", fb_wren, t1_ready, t2_ready);
    end
    sb_en = 1'b1;
    sb_q.push_back('{fb_pack(10'd11, 9'd12), PIX_T1, 1'b0});
    tick();
    t1_valid = 1'b0; t2_valid = 1'b0;
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_erase();
    test_out_of_range();
    test_abandon_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
